// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

  localparam int ADD_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR gate.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  // First half adder on the operand bits, second folds in the carry.
  always_comb begin
    s1   = a ^ b;
    c1   = a & b;
    s    = s1 ^ cin;
    c2   = s1 & cin;
    cout = c1 | c2;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused across WIDTH clocks,
// LSB first, with a start/busy/done handshake that allows back-to-back adds.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cy_q;
  logic             cout_q;

  logic load;
  logic step;
  logic last;
  logic fa_s;
  logic fa_cout;

  serial_fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (cy_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New result bit enters at the MSB so that after WIDTH steps the LSB sits at bit 0.
  assign acc_d = {fa_s, acc_q[WIDTH-1:1]};
  assign last  = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs; start is only honoured in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADD;
          load    = 1'b1;
        end
      end
      ST_ADD: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = ST_ADD;
          load    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift/add, and result update on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      cy_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (load) begin
      a_sh_q <= operand_a;
      b_sh_q <= operand_b;
      cy_q   <= carry_in;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (step) begin
      a_sh_q <= a_sh_q >> 1;
      b_sh_q <= b_sh_q >> 1;
      cy_q   <= fa_cout;
      acc_q  <= acc_d;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) begin
        sum_q  <= acc_d;
        cout_q <= fa_cout;
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int ncmp = 0;
  int nerr = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse start for one cycle, then wait (bounded) for done. done_at is the index of
  // the negedge after the accepting edge at which done was seen (-1 on timeout).
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int nbusy, output int done_at);
    @(negedge clk);
    operand_a = a; operand_b = b; carry_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; operand_a = '0; operand_b = '0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b want=0", busy); end
    ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b want=0", done); end
    ncmp++; if (sum !== 8'h00) begin nerr++; $display("FAIL reset_sum got=%h want=00", sum); end
    ncmp++; if (carry_out !== 1'b0) begin nerr++; $display("FAIL reset_cout got=%b want=0", carry_out); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nb, da;
    run_add(8'h5A, 8'h33, 1'b0, nb, da);
    ncmp++; if (nb != 8) begin nerr++; $display("FAIL basic_busy_cycles got=%0d want=8", nb); end
    ncmp++; if (da != 9) begin nerr++; $display("FAIL basic_done_latency got=%0d want=9", da); end
    ncmp++; if (sum !== 8'h8D) begin nerr++; $display("FAIL basic_sum got=%h want=8d", sum); end
    ncmp++; if (carry_out !== 1'b0) begin nerr++; $display("FAIL basic_cout got=%b want=0", carry_out); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_busy_in_done got=%b want=0", busy); end
    @(negedge clk);
    ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL basic_done_width got=%b want=0", done); end
    ncmp++; if (sum !== 8'h8D) begin nerr++; $display("FAIL basic_sum_hold got=%h want=8d", sum); end
  endtask

  task automatic test_overflow();
    int nb, da;
    run_add(8'hFF, 8'h01, 1'b0, nb, da);
    ncmp++; if (da != 9) begin nerr++; $display("FAIL ovf1_latency got=%0d want=9", da); end
    ncmp++; if ({carry_out, sum} !== 9'h100) begin nerr++; $display("FAIL ovf1_result got=%h want=100", {carry_out, sum}); end
    run_add(8'hFF, 8'hFF, 1'b1, nb, da);
    ncmp++; if (da != 9) begin nerr++; $display("FAIL ovf2_latency got=%0d want=9", da); end
    ncmp++; if ({carry_out, sum} !== 9'h1FF) begin nerr++; $display("FAIL ovf2_result got=%h want=1ff", {carry_out, sum}); end
  endtask

  task automatic test_start_ignored();
    int nd, da;
    logic [W-1:0] got_sum;
    logic         got_cout;
    @(negedge clk);
    operand_a = 8'h10; operand_b = 8'h20; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);            // ADD cycle 1
    start = 1'b0;
    @(negedge clk);            // ADD cycle 2
    @(negedge clk);            // ADD cycle 3
    operand_a = 8'hAA; operand_b = 8'h55; start = 1'b1;
    @(negedge clk);            // ADD cycle 4
    start = 1'b0;
    nd = 0; da = -1; got_sum = '0; got_cout = 1'b0;
    for (int k = 4; k <= 30; k++) begin
      if (done === 1'b1) begin
        nd++;
        if (da < 0) begin da = k; got_sum = sum; got_cout = carry_out; end
      end
      @(negedge clk);
    end
    ncmp++; if (nd != 1) begin nerr++; $display("FAIL ignore_done_count got=%0d want=1", nd); end
    ncmp++; if (da != 9) begin nerr++; $display("FAIL ignore_latency got=%0d want=9", da); end
    ncmp++; if (got_sum !== 8'h30) begin nerr++; $display("FAIL ignore_sum got=%h want=30", got_sum); end
    ncmp++; if (got_cout !== 1'b0) begin nerr++; $display("FAIL ignore_cout got=%b want=0", got_cout); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL ignore_idle_after got=%b want=0", busy); end
  endtask

  task automatic test_abort();
    int nd, nb, da;
    @(negedge clk);
    operand_a = 8'h0F; operand_b = 8'h01; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);            // ADD cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk); // ADD cycle 4
    rst = 1'b1;
    @(negedge clk);
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got=%b want=0", busy); end
    ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL abort_done got=%b want=0", done); end
    ncmp++; if (sum !== 8'h00) begin nerr++; $display("FAIL abort_sum got=%h want=00", sum); end
    ncmp++; if (carry_out !== 1'b0) begin nerr++; $display("FAIL abort_cout got=%b want=0", carry_out); end
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      @(negedge clk);
    end
    ncmp++; if (nd != 0) begin nerr++; $display("FAIL abort_no_done got=%0d want=0", nd); end
    run_add(8'h01, 8'h01, 1'b0, nb, da);
    ncmp++; if (da != 9) begin nerr++; $display("FAIL abort_next_latency got=%0d want=9", da); end
    ncmp++; if ({carry_out, sum} !== 9'h002) begin nerr++; $display("FAIL abort_next_result got=%h want=002", {carry_out, sum}); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    @(negedge clk);
    operand_a = 8'h01; operand_b = 8'h02; carry_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) begin operand_a = 8'h03; operand_b = 8'h04; end
      exp_done = (k == 9) || (k == 18);
      ncmp++; if (done !== exp_done) begin nerr++; $display("FAIL b2b_done k=%0d got=%b want=%b", k, done, exp_done); end
      ncmp++; if (busy !== !exp_done) begin nerr++; $display("FAIL b2b_busy k=%0d got=%b want=%b", k, busy, !exp_done); end
      if (k == 9) begin
        ncmp++; if (sum !== 8'h03) begin nerr++; $display("FAIL b2b_sum1 got=%h want=03", sum); end
      end
      if (k == 18) begin
        ncmp++; if (sum !== 8'h07) begin nerr++; $display("FAIL b2b_sum2 got=%h want=07", sum); end
        start = 1'b0;
      end
    end
    @(negedge clk);
    ncmp++; if (busy !== 1'b0 || done !== 1'b0) begin nerr++; $display("FAIL b2b_idle got=%b%b want=00", busy, done); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, prev_sum;
    logic         c, prev_cout, stable;
    logic [W:0]   exp;
    int           da;
    prev_sum = 8'h07; prev_cout = 1'b0;
    for (int n = 0; n < 500; n++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
      @(negedge clk);
      operand_a = a; operand_b = b; carry_in = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      operand_a = ~a; operand_b = ~b; carry_in = ~c;
      da = -1; stable = 1'b1;
      for (int k = 1; k <= 20; k++) begin
        if (done === 1'b1) begin da = k; break; end
        if (sum !== prev_sum || carry_out !== prev_cout) stable = 1'b0;
        @(negedge clk);
      end
      ncmp++; if (da != 9) begin nerr++; $display("FAIL rnd_latency op=%0d got=%0d want=9", n, da); end
      ncmp++; if (stable !== 1'b1) begin nerr++; $display("FAIL rnd_hold op=%0d got=%b want=1", n, stable); end
      ncmp++; if ({carry_out, sum} !== exp) begin nerr++; $display("FAIL rnd_result op=%0d a=%h b=%h c=%b got=%h want=%h", n, a, b, c, {carry_out, sum}, exp); end
      @(negedge clk);
      ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL rnd_done_width op=%0d got=%b want=0", n, done); end
      prev_sum = exp[W-1:0]; prev_cout = exp[W];
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
